// File: rtl/slow_clock_monitor_if.sv
// Purpose: bundles the slow-clock input with the tick/period/status outputs of the monitor.
// Latency: none, wiring only.
// Backpressure: none; every output is a pulse or level that consumers sample as needed.
interface slow_clock_monitor_if #(
  parameter int CNT_W = 27
);
  logic             slow_in;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             running;
  logic             timeout;

  // Monitor side: consumes the divided clock, drives tick and measurements.
  modport master (
    input  slow_in,
    output tick,
    output period,
    output period_valid,
    output running,
    output timeout
  );

  // Consumer side: supplies the divided clock, uses tick as a clock enable.
  modport slave (
    output slow_in,
    input  tick,
    input  period,
    input  period_valid,
    input  running,
    input  timeout
  );
endinterface

// File: rtl/slow_clock_monitor.sv
// Purpose: synchronize a slow divided clock, emit a tick per rising edge, measure its period, flag stalls.
// Latency: tick and period_valid appear the cycle after edge k+SYNC_STAGES when slow_in is first sampled high at edge k.
// Backpressure: none; tick/period_valid are single-cycle pulses, timeout/running are levels.
module slow_clock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 27,
  parameter int TIMEOUT     = 110_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  slow_clock_monitor_if.master  mon
);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    RUN  = 2'd1,
    TOUT = 2'd2
  } state_t;

  // Last count value before the stall is declared.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   tick_q;
  logic                   pv_q, pv_d;

  // Synchronizer chain plus one extra flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon.slow_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // State, interval counter, measured period and registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WAIT;
      cnt_q    <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tick_q   <= rise;
      pv_q     <= pv_d;
    end
  end

  // Next-state logic: a rise always wins over a coincident timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    period_d = period_q;
    pv_d     = 1'b0;
    case (state_q)
      WAIT: begin
        if (rise) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = TOUT;
        end
      end
      RUN: begin
        if (rise) begin
          // cnt counts from 0 after the previous rise, so the interval is cnt+1.
          period_d = cnt_q + CNT_W'(1);
          pv_d     = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = TOUT;
        end
      end
      TOUT: begin
        // Counter frozen so it cannot wrap; the interval ending at recovery is discarded.
        cnt_d = cnt_q;
        if (rise) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign mon.tick         = tick_q;
  assign mon.period       = period_q;
  assign mon.period_valid = pv_q;
  assign mon.running      = (state_q == RUN);
  assign mon.timeout      = (state_q == TOUT);

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Purpose: directed checks of tick timing, period measurement, timeout and reset behaviour.
// Latency: n/a.
// Backpressure: n/a.
module tb_slow_clock_monitor;

  logic clk;
  logic rst;

  slow_clock_monitor_if #(.CNT_W(8)) mon_if ();

  slow_clock_monitor #(
    .SYNC_STAGES(2),
    .CNT_W      (8),
    .TIMEOUT    (20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int cyc_n         = 0;
  int tick_cnt      = 0;
  int pv_cnt        = 0;
  int pv_no_tick    = 0;
  int tick_tout     = 0;
  int tout_cnt      = 0;
  int run_cnt       = 0;
  int first_tick_cyc = -1;
  int last_tick_cyc  = -1;
  int tout_rise_cyc  = -1;
  int last_period    = -1;
  logic tout_prev    = 1'b0;

  // One clk cycle: drive slow_in, cross the edge, sample outputs 1 ns later.
  task automatic cyc(input logic s);
    mon_if.slow_in = s;
    @(posedge clk);
    #1;
    cyc_n++;
    if (mon_if.tick) begin
      tick_cnt++;
      if (first_tick_cyc < 0) first_tick_cyc = cyc_n;
      last_tick_cyc = cyc_n;
      if (mon_if.timeout) tick_tout++;
    end
    if (mon_if.period_valid) begin
      pv_cnt++;
      last_period = int'(mon_if.period);
      if (!mon_if.tick) pv_no_tick++;
    end
    if (mon_if.timeout) begin
      tout_cnt++;
      if (!tout_prev) tout_rise_cyc = cyc_n;
    end
    if (mon_if.running) run_cnt++;
    tout_prev = mon_if.timeout;
  endtask

  task automatic clr_stats();
    tick_cnt       = 0;
    pv_cnt         = 0;
    pv_no_tick     = 0;
    tick_tout      = 0;
    tout_cnt       = 0;
    run_cnt        = 0;
    first_tick_cyc = -1;
    tout_rise_cyc  = -1;
    last_period    = -1;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1);
      for (int i = 0; i < lo; i++) cyc(1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mon_if.slow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tout_prev = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mon_if.slow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (mon_if.tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %0d want 0", mon_if.tick); end
    vectors++; if (mon_if.period !== 8'd0) begin miscompares++; $display("FAIL reset_period: got %0d want 0", mon_if.period); end
    vectors++; if (mon_if.period_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pv: got %0d want 0", mon_if.period_valid); end
    vectors++; if (mon_if.running !== 1'b0) begin miscompares++; $display("FAIL reset_running: got %0d want 0", mon_if.running); end
    vectors++; if (mon_if.timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %0d want 0", mon_if.timeout); end
    rst = 1'b1;
    clr_stats();
    tout_prev = 1'b0;
    for (int i = 0; i < 19; i++) cyc(1'b0);
    vectors++; if (mon_if.timeout !== 1'b0) begin miscompares++; $display("FAIL idle_timeout_19: got %0d want 0", mon_if.timeout); end
    cyc(1'b0);
    vectors++; if (mon_if.timeout !== 1'b1) begin miscompares++; $display("FAIL idle_timeout_20: got %0d want 1", mon_if.timeout); end
    for (int i = 0; i < 5; i++) cyc(1'b0);
    vectors++; if (run_cnt !== 0) begin miscompares++; $display("FAIL idle_running: got %0d cycles high want 0", run_cnt); end
    vectors++; if (tick_cnt !== 0) begin miscompares++; $display("FAIL idle_ticks: got %0d want 0", tick_cnt); end
  endtask

  task automatic test_square_wave();
    int s;
    do_reset();
    clr_stats();
    s = cyc_n + 1;
    wave(5, 5, 4);
    vectors++; if (first_tick_cyc !== s + 2) begin miscompares++; $display("FAIL sq_first_tick_latency: got %0d want %0d", first_tick_cyc - s, 2); end
    vectors++; if (tick_cnt !== 4) begin miscompares++; $display("FAIL sq_ticks: got %0d want 4", tick_cnt); end
    vectors++; if (pv_cnt !== 3) begin miscompares++; $display("FAIL sq_pv_count: got %0d want 3", pv_cnt); end
    vectors++; if (last_period !== 10) begin miscompares++; $display("FAIL sq_period: got %0d want 10", last_period); end
    vectors++; if (pv_no_tick !== 0) begin miscompares++; $display("FAIL sq_pv_without_tick: got %0d want 0", pv_no_tick); end
    vectors++; if (mon_if.running !== 1'b1) begin miscompares++; $display("FAIL sq_running: got %0d want 1", mon_if.running); end
  endtask

  task automatic test_stuck_and_recover();
    clr_stats();
    for (int i = 0; i < 30; i++) cyc(1'b1);
    vectors++; if (tick_cnt !== 1) begin miscompares++; $display("FAIL stuck_ticks: got %0d want 1", tick_cnt); end
    vectors++; if (tout_rise_cyc - last_tick_cyc !== 20) begin miscompares++; $display("FAIL stuck_timeout_delay: got %0d want 20", tout_rise_cyc - last_tick_cyc); end
    vectors++; if (mon_if.timeout !== 1'b1) begin miscompares++; $display("FAIL stuck_timeout_level: got %0d want 1", mon_if.timeout); end
    vectors++; if (mon_if.period !== 8'd10) begin miscompares++; $display("FAIL stuck_period_held: got %0d want 10", mon_if.period); end
    for (int i = 0; i < 5; i++) cyc(1'b0);
    clr_stats();
    wave(5, 5, 2);
    vectors++; if (tick_cnt !== 2) begin miscompares++; $display("FAIL recover_ticks: got %0d want 2", tick_cnt); end
    vectors++; if (pv_cnt !== 1) begin miscompares++; $display("FAIL recover_pv_count: got %0d want 1", pv_cnt); end
    vectors++; if (last_period !== 10) begin miscompares++; $display("FAIL recover_period: got %0d want 10", last_period); end
    vectors++; if (tick_tout !== 0) begin miscompares++; $display("FAIL recover_tick_during_timeout: got %0d want 0", tick_tout); end
    vectors++; if (mon_if.timeout !== 1'b0) begin miscompares++; $display("FAIL recover_timeout: got %0d want 0", mon_if.timeout); end
  endtask

  task automatic test_boundary();
    do_reset();
    clr_stats();
    wave(5, 15, 3);
    vectors++; if (pv_cnt !== 2) begin miscompares++; $display("FAIL b20_pv_count: got %0d want 2", pv_cnt); end
    vectors++; if (last_period !== 20) begin miscompares++; $display("FAIL b20_period: got %0d want 20", last_period); end
    vectors++; if (tout_cnt !== 0) begin miscompares++; $display("FAIL b20_timeout: got %0d cycles want 0", tout_cnt); end
    clr_stats();
    wave(5, 16, 2);
    vectors++; if (tick_cnt !== 2) begin miscompares++; $display("FAIL b21_ticks: got %0d want 2", tick_cnt); end
    vectors++; if (pv_cnt !== 1) begin miscompares++; $display("FAIL b21_pv_count: got %0d want 1", pv_cnt); end
    vectors++; if (last_period !== 20) begin miscompares++; $display("FAIL b21_period: got %0d want 20", last_period); end
    vectors++; if (tout_cnt !== 1) begin miscompares++; $display("FAIL b21_timeout_cycles: got %0d want 1", tout_cnt); end
    vectors++; if (mon_if.running !== 1'b1) begin miscompares++; $display("FAIL b21_running: got %0d want 1", mon_if.running); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clr_stats();
    wave(5, 5, 3);
    vectors++; if (mon_if.period !== 8'd10) begin miscompares++; $display("FAIL mid_pre_period: got %0d want 10", mon_if.period); end
    #1;
    rst = 1'b0;
    #1;
    vectors++; if (mon_if.period !== 8'd0) begin miscompares++; $display("FAIL mid_period_cleared: got %0d want 0", mon_if.period); end
    vectors++; if (mon_if.running !== 1'b0) begin miscompares++; $display("FAIL mid_running_cleared: got %0d want 0", mon_if.running); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tout_prev = 1'b0;
    clr_stats();
    wave(5, 5, 2);
    vectors++; if (tick_cnt !== 2) begin miscompares++; $display("FAIL mid_ticks: got %0d want 2", tick_cnt); end
    vectors++; if (pv_cnt !== 1) begin miscompares++; $display("FAIL mid_pv_count: got %0d want 1", pv_cnt); end
    vectors++; if (last_period !== 10) begin miscompares++; $display("FAIL mid_period: got %0d want 10", last_period); end
  endtask

  task automatic test_single_pulse();
    for (int i = 0; i < 3; i++) cyc(1'b0);
    clr_stats();
    cyc(1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0);
    vectors++; if (tick_cnt !== 1) begin miscompares++; $display("FAIL pulse_ticks: got %0d want 1", tick_cnt); end
    vectors++; if (pv_cnt !== 1) begin miscompares++; $display("FAIL pulse_pv_count: got %0d want 1", pv_cnt); end
    vectors++; if (last_period !== 13) begin miscompares++; $display("FAIL pulse_period: got %0d want 13", last_period); end
  endtask

  initial begin
    rst = 1'b0;
    mon_if.slow_in = 1'b0;
    test_reset();
    test_square_wave();
    test_stuck_and_recover();
    test_boundary();
    test_reset_mid();
    test_single_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
